// File: rtl/note_sequencer.sv
// Step sequencer that plays short songs from an internal ROM as one-hot tone selects.
// Optional SEQ_LOOP_EN: an end marker restarts the latched song at step 0 instead of finishing.
module note_sequencer #(
    parameter int TICK_CYCLES = 12500000,
    parameter int GAP_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] song_id,
    output logic [4:0] tone_sel,
    output logic       busy,
    output logic       note_strobe,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [23:0] TC_M1  = 24'(TICK_CYCLES - 1);
    localparam logic [3:0]  GAP_M1 = 4'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
    localparam bit          NO_GAP = (GAP_TICKS == 0);

    state_t      state;
    logic [1:0]  song;
    logic [3:0]  idx;
    logic [3:0]  dur_q;
    logic [23:0] tick;
    logic [3:0]  tcnt;

    logic [1:0]  ld_song;
    logic [3:0]  ld_idx;
    logic [6:0]  ld_word;
    logic        ld_end;
    logic [2:0]  ld_note;
    logic [3:0]  ld_dur;
    logic        tick_last;
    logic        play_end;
    logic        gap_end;
    logic        adv;

    // Song ROM: each word is {note[2:0], dur[3:0]}; unlisted steps read as END.
    function automatic logic [6:0] rom(input logic [1:0] s, input logic [3:0] i);
        logic [6:0] w;
        w = {3'd7, 4'd0};
        case ({s, i})
            6'h00: w = {3'd0, 4'd1};
            6'h01: w = {3'd1, 4'd2};
            6'h02: w = {3'd5, 4'd1};
            6'h03: w = {3'd4, 4'd1};
            6'h10: w = {3'd2, 4'd2};
            6'h11: w = {3'd3, 4'd1};
            6'h12: w = {3'd0, 4'd0};
            6'h13: w = {3'd5, 4'd2};
            6'h14: w = {3'd1, 4'd1};
            6'h15: w = {3'd6, 4'd0};
            6'h20: w = {3'd4, 4'd1};
            6'h21: w = {3'd3, 4'd1};
            6'h22: w = {3'd2, 4'd1};
            6'h23: w = {3'd1, 4'd1};
            6'h24: w = {3'd0, 4'd3};
            6'h30: w = {3'd0, 4'd1};
            6'h31: w = {3'd2, 4'd1};
            6'h32: w = {3'd4, 4'd2};
            6'h33: w = {3'd2, 4'd1};
            6'h34: w = {3'd0, 4'd2};
            6'h35: w = {3'd5, 4'd1};
            6'h36: w = {3'd3, 4'd1};
            6'h37: w = {3'd1, 4'd1};
            6'h38: w = {3'd0, 4'd4};
            default: w = {3'd7, 4'd0};
        endcase
        return w;
    endfunction

    // Work out which step loads next and whether it ends the song.
    always_comb begin
        ld_song = (state == S_IDLE) ? song_id : song;
        ld_idx  = (state == S_IDLE) ? 4'd0 : idx + 4'd1;
        ld_end  = (state != S_IDLE) && (idx == 4'd15);
        ld_word = rom(ld_song, ld_idx);
        if (ld_word[6:5] == 2'b11)
            ld_end = 1'b1;
`ifdef SEQ_LOOP_EN
        if (ld_end && state != S_IDLE) begin
            ld_idx  = 4'd0;
            ld_word = rom(song, 4'd0);
            ld_end  = (ld_word[6:5] == 2'b11);
        end
`endif
        ld_note   = ld_word[6:4];
        ld_dur    = (ld_word[3:0] == 4'd0) ? 4'd1 : ld_word[3:0];
        tick_last = (tick == TC_M1);
        play_end  = (state == S_PLAY) && tick_last && (tcnt == dur_q - 4'd1);
        gap_end   = (state == S_GAP) && tick_last && (tcnt == GAP_M1);
        adv       = ((state == S_IDLE) && start) ||
                    (play_end && NO_GAP) || gap_end;
    end

    // Sequencer FSM with registered outputs; stop and rst take priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            song        <= 2'd0;
            idx         <= 4'd0;
            dur_q       <= 4'd1;
            tick        <= 24'd0;
            tcnt        <= 4'd0;
            tone_sel    <= 5'd0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else if (stop) begin
            state       <= S_IDLE;
            idx         <= 4'd0;
            tick        <= 24'd0;
            tcnt        <= 4'd0;
            tone_sel    <= 5'd0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (adv) begin
                tick <= 24'd0;
                tcnt <= 4'd0;
                if (state == S_IDLE)
                    song <= song_id;
                if (ld_end) begin
                    state    <= S_DONE;
                    idx      <= 4'd0;
                    tone_sel <= 5'd0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    state       <= S_PLAY;
                    idx         <= ld_idx;
                    dur_q       <= ld_dur;
                    tone_sel    <= (ld_note < 3'd5) ? (5'b00001 << ld_note) : 5'd0;
                    note_strobe <= (ld_note < 3'd5);
                    busy        <= 1'b1;
                end
            end else begin
                case (state)
                    S_PLAY, S_GAP: begin
                        if (play_end) begin
                            state    <= S_GAP;
                            tone_sel <= 5'd0;
                            tick     <= 24'd0;
                            tcnt     <= 4'd0;
                        end else if (tick_last) begin
                            tick <= 24'd0;
                            tcnt <= tcnt + 4'd1;
                        end else begin
                            tick <= tick + 24'd1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
